// File: rtl/am2910.sv
// am2910 -- Am2910-compatible microprogram sequencer.
//
// Each cycle it selects the next control-store address Y from one of D, R,
// the stack top F, the microprogram counter uPC, or zero. The current
// instruction I and the condition test decide which source is used.
//
// Ports
//   clk    rising-edge clock
//   nRST   asynchronous active-low reset (uPC, R, SP cleared; stack kept)
//   I      sequencer instruction (0..15)
//   D      direct input: branch address or counter load value
//   nCC    condition code, active low
//   nCCEN  condition enable; 1 forces the test to pass
//   CI     carry into the uPC incrementer
//   nRLD   0 loads R from D this cycle, overriding any other R update
//   nOE    0 drives Y, 1 tri-states Y
//   Y      next microinstruction address (combinational)
//   nFULL  0 while the stack holds DEPTH words
//   nPL    pipeline-register D source select, active low
//   nMAP   mapping-PROM D source select, active low
//   nVECT  vector D source select, active low
module am2910 #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [3:0]       I,
  input  logic [WIDTH-1:0] D,
  input  logic             nCC,
  input  logic             nCCEN,
  input  logic             CI,
  input  logic             nRLD,
  input  logic             nOE,
  output logic [WIDTH-1:0] Y,
  output logic             nFULL,
  output logic             nPL,
  output logic             nMAP,
  output logic             nVECT
);

  localparam int SPW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] uPC;
  logic [WIDTH-1:0] rReg;
  logic [SPW-1:0]   sp;
  logic [WIDTH-1:0] stack [DEPTH];

  logic             pass;
  logic             rz;
  logic             full;
  logic [WIDTH-1:0] stackTop;
  logic [WIDTH-1:0] yInt;
  logic             doPush;
  logic             doPop;
  logic             doClear;
  logic             loadR;
  logic             decR;

  assign pass = nCCEN | ~nCC;
  assign rz   = (rReg == '0);
  assign full = (sp == SPW'(DEPTH));

  // An empty stack still presents entry 0 as F.
  assign stackTop = (sp == '0) ? stack[0] : stack[sp - 1'b1];

  always_comb begin
    yInt    = uPC;
    doPush  = 1'b0;
    doPop   = 1'b0;
    doClear = 1'b0;
    loadR   = 1'b0;
    decR    = 1'b0;
    case (I)
      4'd0: begin
        yInt    = '0;
        doClear = 1'b1;
      end
      4'd1: begin
        if (pass) begin
          yInt   = D;
          doPush = 1'b1;
        end
      end
      4'd2: yInt = D;
      4'd3: if (pass) yInt = D;
      4'd4: begin
        doPush = 1'b1;
        loadR  = pass;
      end
      4'd5: begin
        yInt   = pass ? D : rReg;
        doPush = 1'b1;
      end
      4'd6: if (pass) yInt = D;
      4'd7: yInt = pass ? D : rReg;
      4'd8: begin
        if (!rz) begin
          yInt = stackTop;
          decR = 1'b1;
        end else begin
          doPop = 1'b1;
        end
      end
      4'd9: begin
        if (!rz) begin
          yInt = D;
          decR = 1'b1;
        end
      end
      4'd10: begin
        if (pass) begin
          yInt  = stackTop;
          doPop = 1'b1;
        end
      end
      4'd11: begin
        if (pass) begin
          yInt  = D;
          doPop = 1'b1;
        end
      end
      4'd12: loadR = 1'b1;
      4'd13: begin
        if (pass) doPop = 1'b1;
        else      yInt  = stackTop;
      end
      4'd14: ;
      4'd15: begin
        // Two-way branch: counter not exhausted and test failing keeps looping.
        if (!rz && !pass) begin
          yInt = stackTop;
          decR = 1'b1;
        end else if (rz && !pass) begin
          yInt  = D;
          doPop = 1'b1;
        end else begin
          doPop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      uPC  <= '0;
      rReg <= '0;
      sp   <= '0;
    end else begin
      uPC <= yInt + WIDTH'(CI);

      if (!nRLD)      rReg <= D;
      else if (loadR) rReg <= D;
      else if (decR)  rReg <= rReg - 1'b1;

      if (doClear)                 sp <= '0;
      else if (doPush && !full)    sp <= sp + 1'b1;
      else if (doPop && sp != '0)  sp <= sp - 1'b1;
    end
  end

  // Stack storage is deliberately not reset. A push onto a full stack
  // overwrites the top entry; the return address is the pre-edge uPC.
  always_ff @(posedge clk) begin
    if (doPush) stack[full ? SPW'(DEPTH - 1) : sp] <= uPC;
  end

  assign Y     = nOE ? {WIDTH{1'bz}} : yInt;
  assign nFULL = ~full;
  assign nMAP  = ~(I == 4'd2);
  assign nVECT = ~(I == 4'd6);
  assign nPL   = ~((I != 4'd2) && (I != 4'd6));

endmodule

// File: tb/tb_am2910.sv
// Directed bench for the am2910 sequencer: a vector table walking the
// instruction set, then hand-written sequences for tri-state, counted loops,
// stack overflow/underflow and asynchronous reset during a loop.
module tb_am2910;

  logic        clk = 1'b0;
  logic        nRST;
  logic [3:0]  I;
  logic [11:0] D;
  logic        nCC, nCCEN, CI, nRLD, nOE;
  wire  [11:0] Y;
  logic        nFULL, nPL, nMAP, nVECT;

  int checks = 0;
  int failures = 0;

  am2910 #(.WIDTH(12), .DEPTH(5)) dut (
    .clk(clk), .nRST(nRST), .I(I), .D(D), .nCC(nCC), .nCCEN(nCCEN),
    .CI(CI), .nRLD(nRLD), .nOE(nOE), .Y(Y), .nFULL(nFULL),
    .nPL(nPL), .nMAP(nMAP), .nVECT(nVECT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  i;
    logic [11:0] d;
    logic        ncc;
    logic        nccen;
    logic        ci;
    logic        nrld;
    logic [11:0] expY;
  } vec_t;

  vec_t vecs [33];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] selExp(input logic [3:0] i);
    if (i == 4'd2)      return 3'b101;
    else if (i == 4'd6) return 3'b110;
    else                return 3'b011;
  endfunction

  // Drive one instruction, check combinational outputs, then clock it in.
  task automatic step(input string name, input logic [3:0] i, input logic [11:0] d,
                      input logic ncc, input logic nccen, input logic ci, input logic nrld,
                      input logic [11:0] expY, input logic expFull);
    I = i; D = d; nCC = ncc; nCCEN = nccen; CI = ci; nRLD = nrld;
    #2;
    chk({name, "_y"}, 32'(Y), 32'(expY));
    chk({name, "_nfull"}, 32'(nFULL), 32'(expFull));
    chk({name, "_sel"}, 32'({nPL, nMAP, nVECT}), 32'(selExp(i)));
    @(posedge clk);
    #1;
  endtask

  initial begin
    //        I      D        nCC nCCEN CI nRLD  expY
    vecs[0]  = '{4'd14, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000};
    vecs[1]  = '{4'd14, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 12'h001};
    vecs[2]  = '{4'd14, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 12'h002};
    vecs[3]  = '{4'd14, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 12'h003};
    vecs[4]  = '{4'd3,  12'h00F, 1'b0, 1'b0, 1'b1, 1'b1, 12'h00F};
    vecs[5]  = '{4'd1,  12'h200, 1'b0, 1'b0, 1'b1, 1'b1, 12'h200};
    vecs[6]  = '{4'd10, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h010};
    vecs[7]  = '{4'd2,  12'h155, 1'b1, 1'b0, 1'b1, 1'b1, 12'h155};
    vecs[8]  = '{4'd6,  12'h2AA, 1'b1, 1'b1, 1'b1, 1'b1, 12'h2AA};
    vecs[9]  = '{4'd3,  12'h0F0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h2AB};
    vecs[10] = '{4'd1,  12'h300, 1'b1, 1'b0, 1'b1, 1'b1, 12'h2AC};
    vecs[11] = '{4'd0,  12'h123, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000};
    vecs[12] = '{4'd12, 12'h002, 1'b1, 1'b1, 1'b1, 1'b1, 12'h001};
    vecs[13] = '{4'd7,  12'h040, 1'b1, 1'b1, 1'b1, 1'b1, 12'h040};
    vecs[14] = '{4'd7,  12'h080, 1'b1, 1'b0, 1'b1, 1'b1, 12'h002};
    vecs[15] = '{4'd5,  12'h500, 1'b1, 1'b0, 1'b1, 1'b1, 12'h002};
    vecs[16] = '{4'd5,  12'h500, 1'b1, 1'b1, 1'b1, 1'b1, 12'h500};
    vecs[17] = '{4'd11, 12'h600, 1'b0, 1'b0, 1'b1, 1'b1, 12'h600};
    vecs[18] = '{4'd10, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h003};
    vecs[19] = '{4'd9,  12'h100, 1'b1, 1'b1, 1'b1, 1'b1, 12'h100};
    vecs[20] = '{4'd9,  12'h100, 1'b1, 1'b1, 1'b1, 1'b1, 12'h100};
    vecs[21] = '{4'd9,  12'h100, 1'b1, 1'b1, 1'b1, 1'b1, 12'h101};
    vecs[22] = '{4'd14, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1, 12'h102};
    vecs[23] = '{4'd14, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1, 12'h102};
    vecs[24] = '{4'd14, 12'h007, 1'b1, 1'b1, 1'b1, 1'b0, 12'h102};
    vecs[25] = '{4'd7,  12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h007};
    vecs[26] = '{4'd4,  12'h001, 1'b1, 1'b1, 1'b1, 1'b1, 12'h008};
    vecs[27] = '{4'd15, 12'h3C0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h008};
    vecs[28] = '{4'd15, 12'h3C0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h3C0};
    vecs[29] = '{4'd4,  12'h055, 1'b1, 1'b0, 1'b1, 1'b1, 12'h3C1};
    vecs[30] = '{4'd13, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h3C1};
    vecs[31] = '{4'd13, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 12'h3C2};
    vecs[32] = '{4'd7,  12'h000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000};

    // Reset with CONT selected: Y must read 0 before and across an edge.
    nRST = 1'b0; I = 4'd14; D = 12'h000; nCC = 1'b1; nCCEN = 1'b1;
    CI = 1'b1; nRLD = 1'b1; nOE = 1'b0;
    #2;
    chk("reset_y", 32'(Y), 32'h000);
    chk("reset_nfull", 32'(nFULL), 32'd1);
    chk("reset_sel", 32'({nPL, nMAP, nVECT}), 32'(3'b011));
    @(negedge clk);
    chk("reset_hold_y", 32'(Y), 32'h000);
    nRST = 1'b1;

    for (int k = 0; k < 33; k++)
      step($sformatf("vec%0d", k), vecs[k].i, vecs[k].d, vecs[k].ncc, vecs[k].nccen,
           vecs[k].ci, vecs[k].nrld, vecs[k].expY, 1'b1);

    // Output enable only gates the pin; uPC is 1 here.
    I = 4'd14; CI = 1'b1; nRLD = 1'b1; nOE = 1'b1;
    #2;
    checks++;
    if (Y === 12'h001) begin
      failures++;
      $display("FAIL y_hiz: got %h expected high-impedance", Y);
    end
    nOE = 1'b0;
    #2;
    chk("y_reenable", 32'(Y), 32'h001);
    @(posedge clk);
    #1;

    // Counted loop: LDCT 3, PUSH return address, RFCT back to it three times.
    step("rfct_jmp",  4'd3,  12'h01F, 1'b0, 1'b0, 1'b1, 1'b1, 12'h01F, 1'b1);
    step("rfct_ldct", 4'd12, 12'h003, 1'b1, 1'b1, 1'b1, 1'b1, 12'h020, 1'b1);
    step("rfct_push", 4'd4,  12'h003, 1'b1, 1'b0, 1'b1, 1'b1, 12'h021, 1'b1);
    for (int k = 0; k < 3; k++)
      step($sformatf("rfct_loop%0d", k), 4'd8, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 12'h021, 1'b1);
    step("rfct_exit", 4'd8, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 12'h022, 1'b1);

    // Six subroutine calls: fifth fills the stack, sixth overwrites the top.
    step("cjs0", 4'd1, 12'h100, 1'b0, 1'b0, 1'b1, 1'b1, 12'h100, 1'b1);
    step("cjs1", 4'd1, 12'h110, 1'b0, 1'b0, 1'b1, 1'b1, 12'h110, 1'b1);
    step("cjs2", 4'd1, 12'h120, 1'b0, 1'b0, 1'b1, 1'b1, 12'h120, 1'b1);
    step("cjs3", 4'd1, 12'h130, 1'b0, 1'b0, 1'b1, 1'b1, 12'h130, 1'b1);
    chk("cjs3_after_nfull", 32'(nFULL), 32'd1);
    step("cjs4", 4'd1, 12'h140, 1'b0, 1'b0, 1'b1, 1'b1, 12'h140, 1'b1);
    chk("cjs4_after_nfull", 32'(nFULL), 32'd0);
    step("cjs5", 4'd1, 12'h150, 1'b0, 1'b0, 1'b1, 1'b1, 12'h150, 1'b0);
    chk("cjs5_after_nfull", 32'(nFULL), 32'd0);

    // Six returns: the last one pops an empty stack and sees entry 0.
    step("crtn0", 4'd10, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h141, 1'b0);
    step("crtn1", 4'd10, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h121, 1'b1);
    step("crtn2", 4'd10, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h111, 1'b1);
    step("crtn3", 4'd10, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h101, 1'b1);
    step("crtn4", 4'd10, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h023, 1'b1);
    step("crtn5", 4'd10, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h023, 1'b1);

    // SP must have floored at 0: exactly five pushes refill the stack.
    for (int k = 0; k < 5; k++)
      step($sformatf("refill%0d", k), 4'd4, 12'h003, 1'b1, 1'b0, 1'b1, 1'b1,
           12'(12'h024 + k), 1'b1);
    chk("refill_after_nfull", 32'(nFULL), 32'd0);

    // Reset asynchronously in the middle of an RPCT loop with R=5.
    step("rst_ldct", 4'd12, 12'h005, 1'b1, 1'b1, 1'b1, 1'b1, 12'h029, 1'b0);
    step("rst_rpct", 4'd9,  12'h0A0, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0A0, 1'b0);
    nRST = 1'b0;
    #1;
    chk("async_rst_nfull", 32'(nFULL), 32'd1);
    chk("async_rst_rpct_y", 32'(Y), 32'h000);
    I = 4'd7; nCCEN = 1'b0; nCC = 1'b1; D = 12'h0F0;
    #1;
    chk("async_rst_r", 32'(Y), 32'h000);
    I = 4'd14;
    #1;
    chk("async_rst_upc", 32'(Y), 32'h000);
    @(negedge clk);
    nRST = 1'b1;
    step("post_rst0", 4'd14, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1);
    step("post_rst1", 4'd14, 12'h000, 1'b1, 1'b1, 1'b1, 1'b1, 12'h001, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
